// File: rtl/fifo_button_ctrl_pkg.sv
// fifo_button_ctrl_pkg: shared FSM encoding and arbiter grant constants.
package fifo_button_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ, RD_WAIT, CAPTURE} state_t;
  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;
endpackage

// File: rtl/fifo_button_ctrl_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; last_grant only moves on contention.
module rr_arb2
  import fifo_button_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_wr,
  input  logic req_rd,
  output logic gnt_wr,
  output logic gnt_rd
);
  logic last_grant;
  always_comb begin
    gnt_wr = en & req_wr & (~req_rd | (last_grant == GRANT_RD));
    gnt_rd = en & req_rd & (~req_wr | (last_grant == GRANT_WR));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= GRANT_RD;
    else if (en & req_wr & req_rd) last_grant <= gnt_wr ? GRANT_WR : GRANT_RD;
endmodule

// File: rtl/fifo_button_ctrl.sv
// fifo_button_ctrl: sequences FIFO writes/reads from button pulses with full/empty guarding.
module fifo_button_ctrl
  import fifo_button_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_pulse,
  input  logic                       rd_pulse,
  input  logic                       clr_err,
  input  logic [DATA_WIDTH-1:0]      sw_data,
  input  logic                       fifo_full,
  input  logic                       fifo_empty,
  input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
  output logic                       fifo_wr_en,
  output logic [DATA_WIDTH-1:0]      fifo_wr_data,
  output logic                       fifo_rd_en,
  output logic [DATA_WIDTH-1:0]      led_data,
  output logic                       rd_valid,
  output logic                       overflow_err,
  output logic                       underflow_err,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       busy
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(RD_LATENCY + 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(RD_LATENCY > 1 ? RD_LATENCY - 2 : 0);
  state_t state, state_n;
  logic wr_pend, rd_pend, gnt_wr, gnt_rd;
  logic [CW-1:0] wait_cnt, wait_cnt_n;
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == IDLE),
    .req_wr(wr_pend),
    .req_rd(rd_pend),
    .gnt_wr(gnt_wr),
    .gnt_rd(gnt_rd)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = gnt_wr ? (fifo_full ? IDLE : WRITE) :
                         gnt_rd ? (fifo_empty ? IDLE : READ) : IDLE;
      WRITE:   state_n = IDLE;
      READ:    state_n = (RD_LATENCY == 1) ? CAPTURE : RD_WAIT;
      RD_WAIT: state_n = (wait_cnt == '0) ? CAPTURE : RD_WAIT;
      CAPTURE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    wait_cnt_n = (state == READ) ? WAIT_LOAD :
                 (state == RD_WAIT && wait_cnt != '0) ? wait_cnt - 1'b1 : wait_cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      wr_pend       <= 1'b0;
      rd_pend       <= 1'b0;
      wait_cnt      <= '0;
      fifo_wr_en    <= 1'b0;
      fifo_rd_en    <= 1'b0;
      fifo_wr_data  <= '0;
      led_data      <= '0;
      rd_valid      <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      level         <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      wr_pend       <= wr_pulse | (wr_pend & ~gnt_wr);
      rd_pend       <= rd_pulse | (rd_pend & ~gnt_rd);
      wait_cnt      <= wait_cnt_n;
      fifo_wr_en    <= (state_n == WRITE);
      fifo_rd_en    <= (state_n == READ);
      busy          <= (state_n != IDLE);
      fifo_wr_data  <= (gnt_wr & ~fifo_full) ? sw_data : fifo_wr_data;
      led_data      <= (state == CAPTURE) ? fifo_rd_data : led_data;
      rd_valid      <= (state == CAPTURE);
      overflow_err  <= (gnt_wr & fifo_full) | (overflow_err & ~clr_err);
      underflow_err <= (gnt_rd & fifo_empty) | (underflow_err & ~clr_err);
      level         <= (state == WRITE && level != LW'(DEPTH)) ? level + 1'b1 :
                       (state == READ && level != '0) ? level - 1'b1 : level;
    end
endmodule

// File: tb/tb_fifo_button_ctrl.sv
// tb_fifo_button_ctrl: directed checks of fifo_button_ctrl against a small behavioural FIFO.
module tb_fifo_button_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_pulse = 1'b0, rd_pulse = 1'b0, clr_err = 1'b0;
  logic [7:0] sw_data = 8'h00, fifo_rd_data, fifo_wr_data, led_data;
  logic fifo_full, fifo_empty, fifo_wr_en, fifo_rd_en, rd_valid;
  logic overflow_err, underflow_err, busy;
  logic [2:0] level;
  int checks = 0, failures = 0;
  logic [7:0] mem [4];
  logic [2:0] cnt;
  logic [1:0] wp, rp;

  fifo_button_ctrl #(.DATA_WIDTH(8), .DEPTH(4), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse),
    .clr_err(clr_err), .sw_data(sw_data), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_rd_en(fifo_rd_en), .led_data(led_data), .rd_valid(rd_valid),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural 4-deep FIFO with one-cycle read latency
  assign fifo_full  = (cnt == 3'd4);
  assign fifo_empty = (cnt == 3'd0);
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 3'd0; wp <= 2'd0; rp <= 2'd0; fifo_rd_data <= 8'h00;
    end else begin
      if (fifo_wr_en && cnt != 3'd4) begin mem[wp] <= fifo_wr_data; wp <= wp + 2'd1; end
      if (fifo_rd_en && cnt != 3'd0) begin fifo_rd_data <= mem[rp]; rp <= rp + 2'd1; end
      cnt <= cnt + 3'(fifo_wr_en && cnt != 3'd4) - 3'(fifo_rd_en && cnt != 3'd0);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_wr(input logic [7:0] d);
    sw_data = d; wr_pulse = 1'b1; tick(1); wr_pulse = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_pulse = 1'b1; tick(1); rd_pulse = 1'b0;
  endtask

  initial begin
    tick(2);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_wr_data", fifo_wr_data, 0);
    chk("rst_led", led_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_udf", underflow_err, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(1);
    // single write A5
    pulse_wr(8'hA5);
    chk("w_c1_busy", busy, 0);
    chk("w_c1_wr_en", fifo_wr_en, 0);
    tick(1);
    chk("w_c2_wr_en", fifo_wr_en, 1);
    chk("w_c2_wr_data", fifo_wr_data, 8'hA5);
    chk("w_c2_rd_en", fifo_rd_en, 0);
    chk("w_c2_busy", busy, 1);
    tick(1);
    chk("w_c3_wr_en", fifo_wr_en, 0);
    chk("w_c3_level", level, 1);
    // single read
    pulse_rd();
    tick(1);
    chk("r_c2_rd_en", fifo_rd_en, 1);
    chk("r_c2_wr_en", fifo_wr_en, 0);
    tick(1);
    chk("r_c3_rd_en", fifo_rd_en, 0);
    chk("r_c3_rd_valid", rd_valid, 0);
    chk("r_c3_level", level, 0);
    tick(1);
    chk("r_c4_led", led_data, 8'hA5);
    chk("r_c4_rd_valid", rd_valid, 1);
    tick(1);
    chk("r_c5_rd_valid", rd_valid, 0);
    chk("r_c5_busy", busy, 0);
    pulse_wr(8'h11);
    tick(2);
    chk("pre_cont_level", level, 1);
    // contention 1: write first
    sw_data = 8'h22; wr_pulse = 1'b1; rd_pulse = 1'b1;
    tick(1);
    wr_pulse = 1'b0; rd_pulse = 1'b0;
    tick(1);
    chk("c1_c2_wr_en", fifo_wr_en, 1);
    chk("c1_c2_rd_en", fifo_rd_en, 0);
    chk("c1_c2_wr_data", fifo_wr_data, 8'h22);
    tick(1);
    chk("c1_c3_wr_en", fifo_wr_en, 0);
    chk("c1_c3_rd_en", fifo_rd_en, 0);
    tick(1);
    chk("c1_c4_rd_en", fifo_rd_en, 1);
    chk("c1_c4_wr_en", fifo_wr_en, 0);
    tick(2);
    chk("c1_c6_led", led_data, 8'h11);
    chk("c1_c6_rd_valid", rd_valid, 1);
    chk("c1_c6_level", level, 1);
    // contention 2: read first
    sw_data = 8'h33; wr_pulse = 1'b1; rd_pulse = 1'b1;
    tick(1);
    wr_pulse = 1'b0; rd_pulse = 1'b0;
    tick(1);
    chk("c2_c2_rd_en", fifo_rd_en, 1);
    chk("c2_c2_wr_en", fifo_wr_en, 0);
    tick(2);
    chk("c2_c4_led", led_data, 8'h22);
    chk("c2_c4_rd_valid", rd_valid, 1);
    chk("c2_c4_wr_en", fifo_wr_en, 0);
    tick(1);
    chk("c2_c5_wr_en", fifo_wr_en, 1);
    chk("c2_c5_wr_data", fifo_wr_data, 8'h33);
    tick(1);
    chk("c2_c6_level", level, 1);
    chk("c2_c6_busy", busy, 0);
    pulse_rd();
    tick(3);
    chk("drain_led", led_data, 8'h33);
    tick(1);
    chk("drain_level", level, 0);
    // fill to full, then overflow
    for (int i = 0; i < 4; i++) begin
      pulse_wr(8'h40 + 8'(i));
      tick(2);
    end
    chk("fill_level", level, 4);
    pulse_wr(8'h99);
    tick(1);
    chk("ovf_wr_en", fifo_wr_en, 0);
    chk("ovf_flag", overflow_err, 1);
    chk("ovf_level", level, 4);
    chk("ovf_busy", busy, 0);
    tick(3);
    chk("ovf_sticky", overflow_err, 1);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    chk("ovf_clr", overflow_err, 0);
    // clear coinciding with a new overflow: the error wins
    pulse_wr(8'h98);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    chk("ovf_vs_clr", overflow_err, 1);
    chk("ovf_vs_clr_wr_en", fifo_wr_en, 0);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    chk("ovf_clr2", overflow_err, 0);
    for (int i = 0; i < 4; i++) begin
      pulse_rd();
      tick(3);
      chk("fill_drain_led", led_data, 32'h40 + 32'(i));
      chk("fill_drain_valid", rd_valid, 1);
      tick(1);
    end
    chk("empty_level", level, 0);
    // underflow
    pulse_rd();
    chk("udf_c1_busy", busy, 0);
    tick(1);
    chk("udf_flag", underflow_err, 1);
    chk("udf_rd_en", fifo_rd_en, 0);
    chk("udf_busy", busy, 0);
    chk("udf_level", level, 0);
    tick(1);
    chk("udf_c3_busy", busy, 0);
    chk("udf_sticky", underflow_err, 1);
    chk("udf_ovf_clear", overflow_err, 0);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    chk("udf_clr", underflow_err, 0);
    // async reset aborting a read in flight
    pulse_wr(8'h3C);
    tick(2);
    pulse_rd();
    tick(1);
    chk("abort_rd_en_before", fifo_rd_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_rd_en", fifo_rd_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_level", level, 0);
    chk("abort_wr_data", fifo_wr_data, 0);
    chk("abort_led", led_data, 0);
    tick(2);
    chk("abort_rd_valid_held", rd_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("abort_no_rd_valid", rd_valid, 0);
      chk("abort_idle", busy, 0);
      chk("abort_led_zero", led_data, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
